// File: rtl/meas_stream_pkg.sv
// Shared types and helpers for the measurement word serializer.
package meas_stream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        DATA     = 2'd2,
        CHECKSUM = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_TAG = 8'hA5;
    localparam int unsigned ROUND_W = 32;

    // Number of BIT_WIDTH words needed to carry a MEAS_WIDTH vector.
    function automatic int unsigned calc_num_words(input int unsigned meas_width,
                                                   input int unsigned bit_width);
        return (meas_width + bit_width - 1) / bit_width;
    endfunction

endpackage

// File: rtl/meas_word_mux.sv
// Selects one zero-padded BIT_WIDTH slice of the captured measurement vector.
module meas_word_mux
    import meas_stream_pkg::*;
#(
    parameter int unsigned MEAS_WIDTH = 100,
    parameter int unsigned BIT_WIDTH  = 64
) (
    input  logic [MEAS_WIDTH-1:0] shadow,
    input  logic [((calc_num_words(MEAS_WIDTH, BIT_WIDTH) > 1) ?
                   $clog2(calc_num_words(MEAS_WIDTH, BIT_WIDTH)) : 1)-1:0] idx,
    output logic [BIT_WIDTH-1:0]  word_c
);

    localparam int unsigned NUM_WORDS = calc_num_words(MEAS_WIDTH, BIT_WIDTH);
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PAD_W     = NUM_WORDS * BIT_WIDTH;

    logic [PAD_W-1:0] padded;

    assign padded = PAD_W'(shadow);

    always_comb begin
        word_c = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                word_c = padded[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/measurement_word_serializer.sv
// Frames each generator measurement vector as header + data words on a ready/valid stream.
// Optional trailing XOR checksum word enabled by defining MEAS_CHECKSUM_EN.
module measurement_word_serializer
    import meas_stream_pkg::*;
#(
    parameter int unsigned MEAS_WIDTH = 100,
    parameter int unsigned BIT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  meas_valid,
    input  logic [MEAS_WIDTH-1:0] meas_values,
    output logic                  meas_ready,
    output logic [BIT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ROUND_W-1:0]    round_id,
    output logic                  overflow
);

    localparam int unsigned NUM_WORDS = calc_num_words(MEAS_WIDTH, BIT_WIDTH);
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    generate
        if (BIT_WIDTH < 40) begin : g_bad_width
            $error("BIT_WIDTH must be at least 40");
        end
    endgenerate

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [MEAS_WIDTH-1:0] shadow_q;
    logic                  hs, capture, last_word, load_out;
    logic [BIT_WIDTH-1:0]  data_word_c, header_word, out_data_d;
    logic                  out_valid_d, out_last_d;
`ifdef MEAS_CHECKSUM_EN
    logic [BIT_WIDTH-1:0]  csum_q;
`endif

    assign hs         = out_valid & out_ready;
    assign meas_ready = (state_q == IDLE) | (hs & out_last);
    assign capture    = meas_valid & meas_ready;
    assign last_word  = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a strobe on the closing handshake restarts the frame without a bubble
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (meas_valid) state_d = HEADER;
            end
            HEADER: begin
                if (hs) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (hs) begin
                    if (last_word) begin
`ifdef MEAS_CHECKSUM_EN
                        state_d = CHECKSUM;
`else
                        state_d = capture ? HEADER : IDLE;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CHECKSUM: begin
                if (hs) state_d = capture ? HEADER : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    meas_word_mux #(
        .MEAS_WIDTH (MEAS_WIDTH),
        .BIT_WIDTH  (BIT_WIDTH)
    ) u_word_mux (
        .shadow (shadow_q),
        .idx    (idx_d),
        .word_c (data_word_c)
    );

    always_comb begin
        header_word = '0;
        header_word[BIT_WIDTH-1 -: 8] = HEADER_TAG;
        header_word[ROUND_W-1:0]      = round_id;
    end

    // Output word for the state being entered; held while the sink stalls
    always_comb begin
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_data_d  = out_data;
        load_out    = ~out_valid | out_ready;
        if (load_out) begin
            out_valid_d = (state_d != IDLE);
            out_last_d  = 1'b0;
            out_data_d  = '0;
            case (state_d)
                HEADER: out_data_d = header_word;
                DATA: begin
                    out_data_d = data_word_c;
`ifndef MEAS_CHECKSUM_EN
                    out_last_d = (idx_d == LAST_IDX);
`endif
                end
`ifdef MEAS_CHECKSUM_EN
                CHECKSUM: begin
                    out_data_d = csum_q ^ out_data;
                    out_last_d = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            round_id  <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            idx_q     <= idx_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
            if (capture) shadow_q <= meas_values;
            if (hs && (state_q == HEADER)) round_id <= round_id + ROUND_W'(1);
            if (meas_valid && !meas_ready) overflow <= 1'b1;
        end
    end

`ifdef MEAS_CHECKSUM_EN
    // Running XOR of header and data words as they are accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (hs && (state_q == HEADER)) begin
            csum_q <= out_data;
        end else if (hs && (state_q == DATA)) begin
            csum_q <= csum_q ^ out_data;
        end
    end
`endif

endmodule
